// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA descriptor FIFO.
// Status-state encoding and default sizing constants.
package dmac_pkg;

  localparam int DMAC_ADDR_W = 8;
  localparam int DMAC_SIZE_W = 8;
  localparam int DMAC_DEPTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WRITE       = 3'd1,
    ST_READ        = 3'd2,
    ST_RDWR        = 3'd3,
    ST_WR_ERROR    = 3'd4,
    ST_RD_ERROR    = 3'd5,
    ST_WRITE_RDERR = 3'd6
  } dmac_state_e;

endpackage

// File: rtl/dmac_desc_ram.sv
// Descriptor storage: one write port, one registered read port.
// Read register returns zero on cycles without a read.
module dmac_desc_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_re,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // storage write; array is intentionally not reset
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  // registered read, zero when idle
  always_ff @(posedge clk) begin
    if (reset)
      r_rdata <= '0;
    else if (i_re)
      r_rdata <= r_mem[i_raddr];
    else
      r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmac_desc_fifo.sv
// DMA descriptor FIFO with occupancy flags and status FSM.
// Status pulses report the previous cycle's request outcome.
module dmac_desc_fifo
  import dmac_pkg::*;
#(
  parameter int ADDR_W   = DMAC_ADDR_W,
  parameter int SIZE_W   = DMAC_SIZE_W,
  parameter int DEPTH    = DMAC_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CNT_W    = $clog2(DEPTH) + 1,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] in_srcaddr,
  input  logic [ADDR_W-1:0] in_desaddr,
  input  logic [SIZE_W-1:0] in_datasize,
  output logic [ADDR_W-1:0] out_srcaddr,
  output logic [ADDR_W-1:0] out_desaddr,
  output logic [SIZE_W-1:0] out_datasize,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  data_count,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  localparam int DW = 2 * ADDR_W + SIZE_W;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  dmac_state_e      r_state;
  dmac_state_e      w_next;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [DW-1:0]    w_rdata;

  // a same-cycle read frees the slot a write into a full FIFO needs
  always_comb begin
    w_rd_acc = rd_en && !flush && (r_count != '0);
    w_wr_acc = wr_en && !flush &&
               ((r_count < CNT_W'(DEPTH)) || w_rd_acc);
  end

  dmac_desc_ram #(
    .W     (DW),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_acc),
    .i_waddr (r_tail),
    .i_wdata ({in_srcaddr, in_desaddr, in_datasize}),
    .i_re    (w_rd_acc),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  // pointers, occupancy and output-valid tracking
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_acc;
      if (w_wr_acc)
        r_tail <= r_tail + PTR_W'(1);
      if (w_rd_acc)
        r_head <= r_head + PTR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // status state register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // next status from this cycle's accept/reject outcome
  always_comb begin
    w_next = ST_IDLE;
    if (flush)
      w_next = ST_IDLE;
    else if (w_wr_acc && w_rd_acc)
      w_next = ST_RDWR;
    else if (w_wr_acc && rd_en)
      w_next = ST_WRITE_RDERR;
    else if (w_wr_acc)
      w_next = ST_WRITE;
    else if (w_rd_acc)
      w_next = ST_READ;
    else if (wr_en)
      w_next = ST_WR_ERROR;
    else if (rd_en)
      w_next = ST_RD_ERROR;
  end

  // status pulses decoded from state alone
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    unique case (r_state)
      ST_WRITE:       wr_ack = 1'b1;
      ST_READ:        rd_ack = 1'b1;
      ST_RDWR: begin
        wr_ack = 1'b1;
        rd_ack = 1'b1;
      end
      ST_WR_ERROR:    wr_err = 1'b1;
      ST_RD_ERROR:    rd_err = 1'b1;
      ST_WRITE_RDERR: begin
        wr_ack = 1'b1;
        rd_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign {out_srcaddr, out_desaddr, out_datasize} = w_rdata;
  assign out_valid   = r_out_valid;
  assign data_count  = r_count;
  assign full        = (r_count == CNT_W'(DEPTH));
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= CNT_W'(AF_LEVEL));

endmodule

// File: tb/tb_dmac_desc_fifo.sv
// Directed scoreboard bench for dmac_desc_fifo.
// Model FIFO predicts pops; expected outputs queued and compared.
module tb_dmac_desc_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_srcaddr = '0;
  logic [7:0] in_desaddr = '0;
  logic [7:0] in_datasize = '0;
  logic [7:0] out_srcaddr;
  logic [7:0] out_desaddr;
  logic [7:0] out_datasize;
  logic       out_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [3:0] data_count;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;

  int checks = 0;
  int failures = 0;

  logic [23:0] mq[$];
  logic [23:0] expq[$];
  logic        e_wr_ack, e_wr_err, e_rd_ack, e_rd_err;

  dmac_desc_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .flush        (flush),
    .in_srcaddr   (in_srcaddr),
    .in_desaddr   (in_desaddr),
    .in_datasize  (in_datasize),
    .out_srcaddr  (out_srcaddr),
    .out_desaddr  (out_desaddr),
    .out_datasize (out_datasize),
    .out_valid    (out_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .data_count   (data_count),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [23:0] e;
    int n;
    n = mq.size();
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk({ctx, ".out_valid"}, 32'(out_valid), 32'd1);
    end else begin
      e = '0;
      chk({ctx, ".out_valid"}, 32'(out_valid), 32'd0);
    end
    chk({ctx, ".out_desc"},
        {8'h0, out_srcaddr, out_desaddr, out_datasize}, 32'(e));
    chk({ctx, ".count"}, 32'(data_count), 32'(n));
    chk({ctx, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({ctx, ".empty"}, 32'(empty), 32'(n == 0));
    chk({ctx, ".afull"}, 32'(almost_full), 32'(n >= AF));
    chk({ctx, ".wr_ack"}, 32'(wr_ack), 32'(e_wr_ack));
    chk({ctx, ".wr_err"}, 32'(wr_err), 32'(e_wr_err));
    chk({ctx, ".rd_ack"}, 32'(rd_ack), 32'(e_rd_ack));
    chk({ctx, ".rd_err"}, 32'(rd_err), 32'(e_rd_err));
  endtask

  task automatic step(input string ctx, input logic wr,
                      input logic rd, input logic fl,
                      input logic [23:0] d);
    logic ra, wa;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    flush = fl;
    {in_srcaddr, in_desaddr, in_datasize} = d;
    ra = rd && !fl && (mq.size() > 0);
    wa = wr && !fl && ((mq.size() < DEPTH) || ra);
    e_wr_ack = wa;
    e_wr_err = wr && !wa && !fl;
    e_rd_ack = ra;
    e_rd_err = rd && !ra && !fl;
    if (fl) mq.delete();
    if (ra) expq.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    check_all(ctx);
  endtask

  task automatic do_reset(input string ctx, input logic wr,
                          input logic rd);
    @(negedge clk);
    reset = 1'b1;
    wr_en = wr;
    rd_en = rd;
    in_srcaddr = 8'h5A;
    mq.delete();
    expq.delete();
    e_wr_ack = 1'b0;
    e_wr_err = 1'b0;
    e_rd_ack = 1'b0;
    e_rd_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(ctx);
  endtask

  initial begin
    do_reset("rst0", 1'b0, 1'b0);
    do_reset("rst1", 1'b0, 1'b0);
    step("push1", 1, 0, 0, 24'h102004);
    step("pop1", 0, 1, 0, 24'h0);
    step("idle", 0, 0, 0, 24'h0);
    step("rderr", 0, 1, 0, 24'h0);
    for (int i = 0; i < DEPTH; i++)
      step($sformatf("fill%0d", i), 1, 0, 0,
           {8'(8'h40 + i), 8'(8'h80 + i), 8'(i + 1)});
    step("ovf", 1, 0, 0, 24'hEEEEEE);
    step("rdwr_full", 1, 1, 0, 24'hAAAAAA);
    for (int i = 0; i < 20; i++)
      step($sformatf("wrap%0d", i), 1, 1, 0,
           {8'(8'hB0 + i), 8'(8'hC0 + i), 8'(i * 3)});
    for (int i = 0; i < DEPTH; i++)
      step($sformatf("drain%0d", i), 0, 1, 0, 24'h0);
    step("wr_rderr", 1, 1, 0, 24'h333333);
    step("pop33", 0, 1, 0, 24'h0);
    for (int i = 0; i < 5; i++)
      step($sformatf("pre%0d", i), 1, 0, 0,
           {8'(8'h60 + i), 8'h61, 8'h62});
    step("flush", 1, 0, 1, 24'h777777);
    step("postfl", 0, 1, 0, 24'h0);
    for (int i = 0; i < 3; i++)
      step($sformatf("pre2_%0d", i), 1, 0, 0,
           {8'(8'h20 + i), 8'h21, 8'h22});
    step("popmid", 0, 1, 0, 24'h0);
    do_reset("rstmid", 1'b1, 1'b1);
    step("after_rst", 0, 0, 0, 24'h0);
    step("push_rst", 1, 0, 0, 24'h123456);
    step("pop_rst", 0, 1, 0, 24'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmac_desc_fifo.md
DMAC_DESC_FIFO -- requirements
Module: dmac_desc_fifo

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of source/destination address fields.
REQ-002 SHALL have parameter SIZE_W, default 8, width of data-size field.
REQ-003 SHALL have parameter DEPTH, default 8, descriptor entries; power of two, >= 2.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold; range 1..DEPTH-1.
REQ-005 SHALL define CNT_W = log2(DEPTH)+1 and PTR_W = log2(DEPTH).
REQ-006 Ports SHALL be exactly as follows:
  clk  in  1  sole clock; all logic rising-edge.
  reset  in  1  synchronous, active-high reset.
  wr_en  in  1  push request.
  rd_en  in  1  pop request.
  flush  in  1  discard all entries.
  in_srcaddr  in  ADDR_W  descriptor source address.
  in_desaddr  in  ADDR_W  descriptor destination address.
  in_datasize  in  SIZE_W  descriptor transfer size.
  out_srcaddr  out  ADDR_W  popped source address.
  out_desaddr  out  ADDR_W  popped destination address.
  out_datasize  out  SIZE_W  popped size.
  out_valid  out  1  out_* carry a popped descriptor.
  full / empty / almost_full  out  1 each  occupancy flags.
  data_count  out  CNT_W  stored entries, 0..DEPTH.
  wr_ack / wr_err / rd_ack / rd_err  out  1 each  request status pulses.

Function
REQ-007 Write SHALL be accepted when wr_en=1, flush=0, and (count<DEPTH or read accepted same cycle).
REQ-008 Read SHALL be accepted when rd_en=1, flush=0, count>0; a write in the same cycle never makes a read on empty legal.
REQ-009 Accepted write SHALL store all three fields at tail; tail increments modulo DEPTH.
REQ-010 Accepted read SHALL present head entry on out_* with out_valid=1 in the following cycle; head increments modulo DEPTH.
REQ-011 When no read is accepted, out_* SHALL be all-zero and out_valid=0 in the following cycle.
REQ-012 data_count SHALL update +1 (write only), -1 (read only), unchanged (both or neither); never exceeds DEPTH or underflows.
REQ-013 full = (data_count==DEPTH); empty = (data_count==0); almost_full = (data_count>=AF_LEVEL); all from registered count.
REQ-014 Status FSM SHALL have states IDLE, WRITE, READ, RDWR, WR_ERROR, RD_ERROR, WRITE_RDERR; next state from current-cycle accept/reject outcome; flush forces IDLE.
REQ-015 Status outputs SHALL decode from state only: wr_ack in WRITE/RDWR/WRITE_RDERR; rd_ack in READ/RDWR; wr_err in WR_ERROR; rd_err in RD_ERROR/WRITE_RDERR; i.e. one cycle after request.
REQ-016 Rejected requests SHALL leave pointers, count, and storage unchanged.
REQ-017 flush=1 SHALL take priority: head, tail, count to 0, no acks/errors, out_valid=0 next cycle.

Reset
REQ-018 reset=1 at a clock edge SHALL set head=tail=0, data_count=0, state=IDLE, out_*=0, out_valid=0; hence empty=1, full=0, almost_full=0.
REQ-019 Reset asserted mid-operation SHALL abandon in-flight requests with no ack/err; storage array need not be reset.

Structure
REQ-020 Shared package dmac_pkg SHALL hold the status-state encoding and default ADDR_W/SIZE_W/DEPTH constants.
REQ-021 Storage SHALL be sub-module dmac_desc_ram: DEPTH x (2*ADDR_W+SIZE_W), one write port, one registered read port.

Verification
REQ-022 Reset then push {0x10,0x20,0x04} -> next cycle wr_ack=1, data_count=1, empty=0.
REQ-023 Push 8 entries (DEPTH=8), 9th push -> wr_err=1, count stays 8, full=1, almost_full=1 from count 6.
REQ-024 Pop on empty with simultaneous push of 0x33 -> WRITE_RDERR: wr_ack=1, rd_err=1, count=1, out_valid=0.
REQ-025 Full FIFO, simultaneous push 0xAA and pop -> RDWR: oldest entry on out_*, count stays 8, new entry popped last; 20 push/pop cycles verify tail/head wrap order.
REQ-026 Count=5, assert flush with wr_en=1 -> count=0, empty=1, no wr_ack; reset mid-stream -> all outputs zero next cycle.
